regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_sb.sv | 131 +++++++++++++
 tb/tb_regfile_sb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: sweep FSM encoding and the
// default geometry used by decode and the hazard units.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_state_e;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;

  // Number of registers addressed by an index of the given width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits. Arbitrates reserve against release and produces
// reserve_ok and the per-read-port busy flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_RD     = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // live: out of reset and the sweep FSM is idle
  input  logic                     live,
  input  logic                     sweep_en,
  input  logic [ADDR_W-1:0]        sweep_idx,
  // wr_commit already excludes the zero register and non-idle cycles
  input  logic                     wr_commit,
  input  logic [ADDR_W-1:0]        wr_idx,
  input  logic                     rsv_req,
  input  logic [ADDR_W-1:0]        rsv_idx,
  input  logic [N_RD*ADDR_W-1:0]   rd_idx,
  input  logic [N_RD-1:0]          rd_bypass,
  output logic [N_RD-1:0]          rd_busy,
  output logic                     rsv_ok
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pending;
  logic             rsv_zero;
  logic             rsv_same_wr;

  // Reserve acceptance: free register, or one being released this very cycle.
  always_comb begin
    rsv_zero    = (ZERO_EN != 0) && (rsv_idx == ZERO_IDX);
    rsv_same_wr = wr_commit && (wr_idx == rsv_idx);
    rsv_ok      = live && rsv_req && (rsv_zero || !pending[rsv_idx] || rsv_same_wr);
  end

  // Busy flags: a bypassed write satisfies the hazard in the same cycle.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < N_RD; i++) begin
      rd_busy[i] = pending[rd_idx[i*ADDR_W +: ADDR_W]] & ~rd_bypass[i];
    end
  end

  // Pending update; the reserve is applied last so it wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (sweep_en)              pending[sweep_idx] <= 1'b0;
      if (wr_commit)             pending[wr_idx]    <= 1'b0;
      if (rsv_ok && !rsv_zero)   pending[rsv_idx]   <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass, hardwired zero register,
// scoreboard and a sequenced clear sweep.
// Handshake: there is no backpressure; REGWRITE/RESERVE/CLEAR are one-cycle
// requests sampled on the rising edge, RESERVE is accepted only when
// reserve_ok is high in that same cycle, and any request arriving while
// clear_busy is high is dropped rather than held.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_RD     = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   REGWRITE,
  input  logic [ADDR_W-1:0]      write_reg,
  input  logic [DATA_W-1:0]      writeData,
  input  logic [N_RD*ADDR_W-1:0] read_addr,
  output logic [N_RD*DATA_W-1:0] read_data,
  output logic [N_RD-1:0]        read_busy,
  input  logic                   RESERVE,
  input  logic [ADDR_W-1:0]      reserve_reg,
  output logic                   reserve_ok,
  input  logic                   CLEAR,
  output logic                   clear_busy,
  output fsm_state_e             fsm_state
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  fsm_state_e          state;
  fsm_state_e          state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic                live;
  logic                sweep_en;
  logic                wr_commit;
  logic [N_RD-1:0]     bypass;
  logic [DATA_W-1:0]   regs [DEPTH];

  // Sweep FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Sweep FSM next state: start on CLEAR, finish after the last index.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLEAR) state_nxt = SWEEP;
      SWEEP:   if (cnt == LAST_IDX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep FSM outputs; clear_busy follows the state register directly.
  always_comb begin
    live       = RESET_N && (state == IDLE);
    sweep_en   = (state == SWEEP);
    clear_busy = (state == SWEEP);
    fsm_state  = state;
  end

  // Sweep counter advances once per sweep cycle and wraps back to zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      cnt <= '0;
    else if (sweep_en) cnt <= cnt + ADDR_W'(1);
  end

  // A write takes effect only when idle and not aimed at the zero register.
  always_comb begin
    wr_commit = live && REGWRITE && !((ZERO_EN != 0) && (write_reg == ZERO_IDX));
  end

  // Register array: sweep zeroing has priority, otherwise commit the write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (sweep_en) begin
      regs[cnt] <= '0;
    end else if (wr_commit) begin
      regs[write_reg] <= writeData;
    end
  end

  // Combinational read ports with zero register and same-cycle write bypass.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    idx       = '0;
    read_data = '0;
    bypass    = '0;
    for (int i = 0; i < N_RD; i++) begin
      idx = read_addr[i*ADDR_W +: ADDR_W];
      if ((ZERO_EN != 0) && (idx == ZERO_IDX)) begin
        read_data[i*DATA_W +: DATA_W] = '0;
      end else if (wr_commit && (write_reg == idx)) begin
        bypass[i]                     = 1'b1;
        read_data[i*DATA_W +: DATA_W] = writeData;
      end else begin
        read_data[i*DATA_W +: DATA_W] = regs[idx];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_EN  (ZERO_EN),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .live      (live),
    .sweep_en  (sweep_en),
    .sweep_idx (cnt),
    .wr_commit (wr_commit),
    .wr_idx    (write_reg),
    .rsv_req   (RESERVE),
    .rsv_idx   (reserve_reg),
    .rd_idx    (read_addr),
    .rd_bypass (bypass),
    .rd_busy   (read_busy),
    .rsv_ok    (reserve_ok)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed steps from the feature list followed by a
// randomized phase, all checked against a behavioural model of the file.
module tb_regfile_sb;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int N_RD   = 2;
  localparam int DEPTH  = 32;
  localparam int ZREG   = 31;

  // ---------------- clock / reset / DUT ----------------
  logic                   CLK;
  logic                   RESET_N;
  logic                   REGWRITE;
  logic [ADDR_W-1:0]      write_reg;
  logic [DATA_W-1:0]      writeData;
  logic [N_RD*ADDR_W-1:0] read_addr;
  logic [N_RD*DATA_W-1:0] read_data;
  logic [N_RD-1:0]        read_busy;
  logic                   RESERVE;
  logic [ADDR_W-1:0]      reserve_reg;
  logic                   reserve_ok;
  logic                   CLEAR;
  logic                   clear_busy;
  logic                   fsm_state;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  regfile_sb dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REGWRITE    (REGWRITE),
    .write_reg   (write_reg),
    .writeData   (writeData),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .read_busy   (read_busy),
    .RESERVE     (RESERVE),
    .reserve_reg (reserve_reg),
    .reserve_ok  (reserve_ok),
    .CLEAR       (CLEAR),
    .clear_busy  (clear_busy),
    .fsm_state   (fsm_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] mem  [DEPTH];
  bit                pend [DEPTH];
  bit                m_sweep;
  int                m_pos;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_pos   = 0;
  endtask

  function automatic bit model_bypass(input logic [ADDR_W-1:0] a);
    return RESET_N && !m_sweep && REGWRITE && (write_reg == a) && (int'(a) != ZREG);
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (int'(a) == ZREG) return '0;
    if (model_bypass(a)) return writeData;
    return mem[a];
  endfunction

  function automatic bit model_rsv_ok();
    return RESET_N && RESERVE && !m_sweep &&
           (int'(reserve_reg) == ZREG || !pend[reserve_reg] ||
            (REGWRITE && write_reg == reserve_reg));
  endfunction

  // What the file holds after a rising edge with the current inputs.
  task automatic model_edge();
    bit ok;
    if (m_sweep) begin
      mem[m_pos]  = '0;
      pend[m_pos] = 1'b0;
      m_pos++;
      if (m_pos == DEPTH) begin
        m_sweep = 1'b0;
        m_pos   = 0;
      end
    end else begin
      ok = model_rsv_ok();
      if (REGWRITE && int'(write_reg) != ZREG) begin
        mem[write_reg]  = writeData;
        pend[write_reg] = 1'b0;
      end
      if (ok && int'(reserve_reg) != ZREG) pend[reserve_reg] = 1'b1;
      if (CLEAR) begin
        m_sweep = 1'b1;
        m_pos   = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    REGWRITE    = 1'b0;
    write_reg   = '0;
    writeData   = '0;
    RESERVE     = 1'b0;
    reserve_reg = '0;
    CLEAR       = 1'b0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    read_addr = {a1, a0};
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    REGWRITE  = 1'b1;
    write_reg = r;
    writeData = d;
  endtask

  task automatic do_reserve(input logic [ADDR_W-1:0] r);
    RESERVE     = 1'b1;
    reserve_reg = r;
  endtask

  // Check all outputs mid-cycle against the model, then advance one edge.
  task automatic tick();
    logic [ADDR_W-1:0] a;
    @(negedge CLK);
    for (int i = 0; i < N_RD; i++) begin
      a = read_addr[i*ADDR_W +: ADDR_W];
      check($sformatf("read_data%0d x%0d", i, a), read_data[i*DATA_W +: DATA_W], model_read(a));
      check($sformatf("read_busy%0d x%0d", i, a), 64'(read_busy[i]),
            64'(pend[a] && !model_bypass(a)));
    end
    check("reserve_ok", 64'(reserve_ok), 64'(model_rsv_ok()));
    check("clear_busy", 64'(clear_busy), 64'(m_sweep));
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? ADDR_W'(ZREG) : ADDR_W'(r);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    RESET_N = 1'b0;
    idle_inputs();
    model_reset();
    // Requests present during reset must have no visible effect.
    do_write(5'd3, 64'd5);
    do_reserve(5'd5);
    set_rd(5'd3, 5'd3);
    #12;
    check("reset read_data", read_data[63:0], 64'd0);
    check("reset read_data1", read_data[127:64], 64'd0);
    check("reset read_busy", 64'(read_busy), 64'd0);
    check("reset reserve_ok", 64'(reserve_ok), 64'd0);
    check("reset clear_busy", 64'(clear_busy), 64'd0);
    idle_inputs();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Reads after reset, then write X3 and read it back.
    set_rd(5'd1, 5'd2);
    tick();
    do_write(5'd3, 64'd12345);
    tick();
    idle_inputs();
    set_rd(5'd3, 5'd0);
    #1;
    check("x3 after write", read_data[63:0], 64'd12345);
    tick();

    // Same-cycle bypass.
    do_write(5'd7, 64'hABCD);
    set_rd(5'd7, 5'd3);
    #1;
    check("bypass x7", read_data[63:0], 64'hABCD);
    tick();
    idle_inputs();

    // Zero register: write dropped, reserve accepted without pending.
    do_write(5'd31, 64'd99999);
    set_rd(5'd31, 5'd7);
    tick();
    idle_inputs();
    tick();
    do_reserve(5'd31);
    #1;
    check("reserve x31 ok", 64'(reserve_ok), 64'd1);
    tick();
    idle_inputs();
    #1;
    check("x31 busy", 64'(read_busy[0]), 64'd0);

    // Scoreboard: reserve, busy, refused re-reserve, release by write.
    do_reserve(5'd5);
    set_rd(5'd5, 5'd31);
    tick();
    #1;
    check("x5 busy after reserve", 64'(read_busy[0]), 64'd1);
    check("x5 second reserve", 64'(reserve_ok), 64'd0);
    tick();
    idle_inputs();
    do_write(5'd5, 64'd42);
    #1;
    check("x5 busy drops on write", 64'(read_busy[0]), 64'd0);
    tick();
    idle_inputs();
    tick();

    // Write and reserve of the same register in one cycle.
    do_write(5'd9, 64'd7);
    do_reserve(5'd9);
    set_rd(5'd9, 5'd5);
    #1;
    check("x9 reserve with write", 64'(reserve_ok), 64'd1);
    tick();
    idle_inputs();
    #1;
    check("x9 data", read_data[63:0], 64'd7);
    check("x9 stays busy", 64'(read_busy[0]), 64'd1);
    tick();

    // Preload X0..X30 then sweep; a mid-sweep write to X0 is dropped.
    for (int i = 0; i < ZREG; i++) begin
      do_write(ADDR_W'(i), 64'(i * 1000 + 17));
      set_rd(ADDR_W'(i), ADDR_W'(30 - i));
      tick();
    end
    idle_inputs();
    CLEAR = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(31 - i));
      if (i == 10) begin
        do_write(5'd0, 64'd555);
        do_reserve(5'd1);
        CLEAR = 1'b1;
      end
      #1;
      check($sformatf("clear_busy sweep %0d", i), 64'(clear_busy), 64'd1);
      tick();
      idle_inputs();
    end
    #1;
    check("clear_busy after sweep", 64'(clear_busy), 64'd0);
    for (int i = 0; i < DEPTH / 2; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(i + 16));
      tick();
    end

    // Reset in the middle of a sweep.
    for (int i = 0; i < 8; i++) begin
      do_write(ADDR_W'(i + 20), 64'(i + 1));
      tick();
    end
    idle_inputs();
    CLEAR = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    RESET_N = 1'b0;
    #1;
    model_reset();
    check("clear_busy on reset", 64'(clear_busy), 64'd0);
    #2;
    RESET_N = 1'b1;
    set_rd(5'd25, 5'd21);
    tick();
    tick();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      idle_inputs();
      if ($urandom_range(0, 1) == 1) do_write(rnd_addr(), {$urandom(), $urandom()});
      if ($urandom_range(0, 2) == 0) do_reserve(rnd_addr());
      if ($urandom_range(0, 59) == 0) CLEAR = 1'b1;
      set_rd(rnd_addr(), rnd_addr());
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
